// File: rtl/result_collector.sv
// Collects results from an upstream combine stage into a small FWFT FIFO and
// keeps a rotate-XOR checksum, a saturating result count and a sticky overflow flag.
module result_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] checksum,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             push;
    logic             pop;

    function automatic logic [WIDTH-1:0] rotl_xor(input logic [WIDTH-1:0] sum,
                                                  input logic [WIDTH-1:0] data);
        return {sum[WIDTH-2:0], sum[WIDTH-1]} ^ data;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    // Flags come straight from the occupancy register, so in_ready never
    // depends combinationally on in_valid.
    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    assign push = in_valid & ~full;
    assign pop  = out_ready & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // clr wins over a same-cycle push: the data still lands in the FIFO but is
    // not folded into checksum or count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            checksum <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                checksum <= rotl_xor(checksum, in_data);
                count    <= sat_inc(count);
            end
            if (in_valid && full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: default instance for FIFO/checksum
// behaviour, a CNT_W=2 instance for count saturation and clear.
module tb_result_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       clr_a = 0, in_valid_a = 0, out_ready_a = 0;
    logic [7:0] in_data_a = 0;
    logic       in_ready_a, out_valid_a, full_a, empty_a, overflow_a;
    logic [7:0] out_data_a, checksum_a;
    logic [15:0] count_a;

    logic       clr_b = 0, in_valid_b = 0, out_ready_b = 0;
    logic [7:0] in_data_b = 0;
    logic       in_ready_b, out_valid_b, full_b, empty_b, overflow_b;
    logic [7:0] out_data_b, checksum_b;
    logic [1:0] count_b;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    result_collector #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .clr(clr_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
        .full(full_a), .empty(empty_a), .checksum(checksum_a),
        .count(count_a), .overflow(overflow_a)
    );

    result_collector #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .clr(clr_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
        .full(full_b), .empty(empty_b), .checksum(checksum_b),
        .count(count_b), .overflow(overflow_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] v);
        in_valid_a = 1'b1;
        in_data_a  = v;
        qa.push_back(v);
        cycle();
        in_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] v);
        in_valid_b = 1'b1;
        in_data_b  = v;
        qb.push_back(v);
        cycle();
        in_valid_b = 1'b0;
    endtask

    // Scoreboard monitors: each handshake seen at the falling edge is one pop.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) chk("a_unexpected_pop", {24'd0, out_data_a}, 32'hFFFF_FFFF);
            else chk("a_out_data", {24'd0, out_data_a}, {24'd0, qa.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) chk("b_unexpected_pop", {24'd0, out_data_b}, 32'hFFFF_FFFF);
            else chk("b_out_data", {24'd0, out_data_b}, {24'd0, qb.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12 rst = 1'b0;
        // Reset state
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_checksum", checksum_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_overflow", overflow_a, 0);
        chk("rst_b_count", count_b, 0);
        cycle();

        // Single result
        push_a(8'd29);
        chk("single_out_valid", out_valid_a, 1);
        chk("single_out_data", out_data_a, 29);
        chk("single_checksum", checksum_a, 8'h1D);
        chk("single_count", count_a, 1);
        chk("single_empty", empty_a, 0);
        out_ready_a = 1; cycle(); out_ready_a = 0;
        chk("single_drained", empty_a, 1);

        // Checksum order
        clr_a = 1; cycle(); clr_a = 0;
        chk("clr_checksum", checksum_a, 0);
        chk("clr_count", count_a, 0);
        push_a(8'h1D);
        push_a(8'h0F);
        chk("order_checksum2", checksum_a, 8'h35);
        push_a(8'h80);
        chk("order_checksum3", checksum_a, 8'hEA);
        chk("order_count3", count_a, 3);
        out_ready_a = 1; repeat (3) cycle(); out_ready_a = 0;
        chk("order_drained", empty_a, 1);

        // Fill and overflow
        clr_a = 1; cycle(); clr_a = 0;
        for (int v = 1; v <= 4; v++) push_a(v[7:0]);
        chk("fill_full", full_a, 1);
        chk("fill_in_ready", in_ready_a, 0);
        chk("fill_checksum", checksum_a, 8'h02);
        chk("fill_overflow_clear", overflow_a, 0);
        in_valid_a = 1; in_data_a = 8'd5; cycle();
        chk("ovf_set", overflow_a, 1);
        chk("ovf_count", count_a, 4);
        chk("ovf_checksum", checksum_a, 8'h02);
        out_ready_a = 1; cycle(); in_valid_a = 0;
        chk("full_pop_only_full", full_a, 0);
        chk("full_pop_only_count", count_a, 4);
        chk("ovf_sticky", overflow_a, 1);
        repeat (4) cycle();
        out_ready_a = 0;
        chk("fill_drained_empty", empty_a, 1);
        chk("fill_drained_valid", out_valid_a, 0);

        // Simultaneous push/pop at occupancy 2, across pointer wrap
        push_a(8'd10);
        push_a(8'd11);
        out_ready_a = 1;
        for (int v = 12; v <= 20; v++) begin
            push_a(v[7:0]);
            chk("stream_full", full_a, 0);
            chk("stream_empty", empty_a, 0);
        end
        repeat (2) cycle();
        out_ready_a = 0;
        chk("stream_drained", empty_a, 1);

        // Reset mid-operation, between edges
        push_a(8'd30);
        push_a(8'd31);
        push_a(8'd32);
        #3 rst = 1'b1;
        #1;
        chk("midrst_empty", empty_a, 1);
        chk("midrst_out_valid", out_valid_a, 0);
        chk("midrst_checksum", checksum_a, 0);
        chk("midrst_count", count_a, 0);
        #1 rst = 1'b0;
        qa.delete();
        cycle();
        push_a(8'd7);
        chk("post_rst_data", out_data_a, 7);
        out_ready_a = 1; cycle(); out_ready_a = 0;

        // Saturation and clear on the CNT_W=2 instance
        for (int v = 1; v <= 4; v++) push_b(v[7:0]);
        in_valid_b = 1; in_data_b = 8'd5; cycle(); in_valid_b = 0;
        chk("sat_count", count_b, 3);
        chk("sat_full", full_b, 1);
        chk("sat_overflow", overflow_b, 1);
        chk("sat_checksum", checksum_b, 8'h02);
        out_ready_b = 1; cycle(); out_ready_b = 0;
        clr_b = 1;
        push_b(8'hFF);
        clr_b = 0;
        chk("clr_push_checksum", checksum_b, 0);
        chk("clr_push_count", count_b, 0);
        chk("clr_push_overflow", overflow_b, 0);
        chk("clr_push_full", full_b, 1);
        out_ready_b = 1; repeat (4) cycle(); out_ready_b = 0;
        chk("b_drained", empty_b, 1);

        chk("qa_leftover", qa.size(), 0);
        chk("qb_leftover", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Downstream stage for the registered 8-bit bitwise-combine blocks (e.g. and_comb).
- Captures each produced result into a small first-word-fall-through FIFO, drained by a ready/valid consumer.
- Maintains a running rotate-XOR checksum, a saturating result count and a sticky overflow flag, so benches can compare a whole run against a simulator reference.

Parameters:
- WIDTH, 8, data width of results, FIFO entries and checksum
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 16, width of the saturating result counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of checksum, count and overflow only
- in_valid  input  1  producer presents a result
- in_data  input  WIDTH  result value
- in_ready  output  1  collector can accept; equals !full
- out_valid  output  1  FIFO head valid; equals !empty
- out_data  output  WIDTH  FIFO head, combinational from storage
- out_ready  input  1  consumer takes the head
- full  output  1  occupancy == DEPTH
- empty  output  1  occupancy == 0
- checksum  output  WIDTH  running checksum of accepted results
- count  output  CNT_W  accepted results, saturating
- overflow  output  1  sticky: in_valid seen while full

Behaviour:
- Reset (async, immediate, independent of clk):
  - read/write pointers and occupancy 0, so empty=1, full=0, in_ready=1, out_valid=0.
  - checksum=0, count=0, overflow=0.
  - out_data undefined while empty; the bench must not check it.
  - FIFO contents are not cleared.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same rising edge.
- Push writes in_data at wr_ptr. wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Pop advances rd_ptr modulo DEPTH. The next entry appears on out_data in the same cycle the pointer updates.
- Occupancy: push only +1, pop only -1, push and pop 0.
- Latency: a value pushed into an empty FIFO at edge N drives out_valid=1 and out_data=value from just after edge N, i.e. one cycle.
- Full, with in_valid and out_ready both high: in_ready is 0, so only the pop occurs and occupancy becomes DEPTH-1. No same-cycle pass-through on full.
- Empty: out_ready is ignored and nothing pops. A push into an empty FIFO is visible from the next cycle.
- Checksum on each push: checksum <= {checksum[WIDTH-2:0], checksum[WIDTH-1]} ^ in_data. This is a rotate-left by 1, with the MSB wrapping to the LSB.
- Count increments by 1 on each push and holds at 2^CNT_W-1. It never wraps.
- Overflow is set on any edge with in_valid=1 and full=1. It stays set until rst or clr.
- clr (synchronous) zeroes checksum, count and overflow, and takes priority over a same-cycle push update.
  - The pushed data still enters the FIFO.
  - That push is not reflected in checksum or count.
  - FIFO pointers are unaffected by clr.
- All outputs except out_data derive directly from registers; there is no combinational path from in_valid to in_ready.

Test Plan:
- Single result: after reset, push 8'd29 (29 & 95) with out_ready=0.
  - Next cycle: out_valid=1, out_data=29, checksum=8'h1D, count=1, empty=0.
- Checksum order: push 8'h1D then 8'h0F -> checksum=8'h35. Then push 8'h80 -> checksum=8'hEA (rotl 8'h35 = 8'h6A, XOR 8'h80), count=3.
- Fill and overflow, with out_ready=0:
  - push 1,2,3,4 -> full=1, in_ready=0.
  - hold in_valid=1 with 5 -> overflow=1, count=4, checksum unchanged.
  - then out_ready=1 -> out_data sequence 1,2,3,4, then empty=1.
- Simultaneous push/pop: hold occupancy at 2 while streaming 10..20.
  - Occupancy stays 2, full and empty stay low.
  - Outputs are 10..20 in order across pointer wrap.
- Reset mid-operation: after 3 pushes, pulse rst between clock edges.
  - empty=1, out_valid=0, checksum=0, count=0 immediately, before the next edge.
  - Then push 7 -> out_data=7.
- Saturation and clear, with CNT_W=2:
  - 5 pushes -> count=3.
  - clr coincident with a push of 8'hFF -> checksum=0, count=0, overflow=0, and 8'hFF is still delivered at out_data.
